// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//
// Byte-stream boot loader for one CPU memory bank. A frame from the serial
// receiver is a 16-bit little-endian word count N followed by N words, each
// sent low byte first. Every assembled word is written to the next address of
// the OpenRAM bank using the bank's active-low en/rw strobes. The attached CPU
// is held in reset (cpu_hold) for the duration of a load.
//
// Parameters
//   ADDR_W   memory word-address width; bank depth is 2**ADDR_W (ADDR_W <= 16)
//   TIMEOUT  idle cycles tolerated between bytes of a frame before aborting
//
// Ports
//   soc_clk      in   1       clock
//   soc_rst      in   1       synchronous reset, active high
//   start        in   1       rising edge in IDLE/DONE/ERR begins a load
//   rx_valid     in   1       receiver has a byte; held until accepted
//   rx_data      in   8       receiver byte
//   rx_ready     out  1       byte accepted when rx_valid & rx_ready at posedge
//   addr_to_mem  out  ADDR_W  memory word address
//   data_to_mem  out  16      memory write data
//   en_to_memB   out  1       memory enable, active low
//   rw_to_mem    out  1       0 = write, 1 = read
//   cpu_hold     out  1       high while a load is in progress
//   done         out  1       sticky: last load completed
//   err          out  1       sticky: last load aborted (bad length / timeout)
// -----------------------------------------------------------------------------
module mem_loader #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 4095
) (
    input  logic              soc_clk,
    input  logic              soc_rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic [15:0]       data_to_mem,
    output logic              en_to_memB,
    output logic              rw_to_mem,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int DEPTH  = 1 << ADDR_W;
    // Remaining-word counter must hold the full depth (N == 2**ADDR_W).
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               start_q;
    logic [7:0]         len_lo;
    logic [CNT_W-1:0]   remaining;
    logic [IDLE_W-1:0]  idle_cnt;

    logic               start_rise;
    logic               accept;
    logic               timeout_hit;
    logic [15:0]        len_word;
    logic               len_too_big;
    logic               load_start;
    logic               enter_done;
    logic               enter_err;

    assign start_rise  = start && !start_q;
    assign accept      = rx_valid && rx_ready;
    // The cycle that would push the idle count to TIMEOUT aborts the frame.
    assign timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign len_word    = {rx_data, len_lo};
    assign len_too_big = ({16'd0, len_word} > 32'(DEPTH));

    assign load_start  = (next_state == S_LEN_LO) && (state != S_LEN_LO);
    assign enter_done  = (next_state == S_DONE) && (state != S_DONE);
    assign enter_err   = (next_state == S_ERR) && (state != S_ERR);

    // -------------------------------------------------------------------------
    // Next-state and decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        next_state = state;
        rx_ready   = 1'b0;
        en_to_memB = 1'b1;
        rw_to_mem  = 1'b1;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_rise) begin
                    next_state = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    next_state = S_LEN_HI;
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end
            end

            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (len_word == 16'd0) begin
                        next_state = S_DONE;
                    end else if (len_too_big) begin
                        next_state = S_ERR;
                    end else begin
                        next_state = S_DAT_LO;
                    end
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end
            end

            S_DAT_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    next_state = S_DAT_HI;
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end
            end

            S_DAT_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    next_state = S_WRITE;
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end
            end

            S_WRITE: begin
                // Single-cycle write strobe; the receiver is stalled meanwhile.
                en_to_memB = 1'b0;
                rw_to_mem  = 1'b0;
                if (remaining == CNT_W'(1)) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_DAT_LO;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge soc_clk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // sees the pre-edge value of every other register.
        if (soc_rst) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            len_lo      <= 8'd0;
            remaining   <= '0;
            idle_cnt    <= '0;
            addr_to_mem <= '0;
            data_to_mem <= 16'd0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state   <= next_state;
            start_q <= start;

            // Idle counter restarts on any accepted byte or state change and
            // only advances while a byte is being waited for.
            if (accept || (next_state != state)) begin
                idle_cnt <= '0;
            end else if (rx_ready) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (load_start) begin
                done        <= 1'b0;
                err         <= 1'b0;
                addr_to_mem <= '0;
                cpu_hold    <= 1'b1;
            end

            if (enter_done) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end

            if (enter_err) begin
                err      <= 1'b1;
                cpu_hold <= 1'b0;
            end

            if (accept) begin
                case (state)
                    S_LEN_LO: len_lo            <= rx_data;
                    // Only used when the length is in range; truncation of an
                    // oversized count is harmless because that path aborts.
                    S_LEN_HI: remaining         <= CNT_W'(len_word);
                    S_DAT_LO: data_to_mem[7:0]  <= rx_data;
                    S_DAT_HI: data_to_mem[15:8] <= rx_data;
                    default: ;
                endcase
            end

            // Address wraps naturally to 0 after the last word of a full bank.
            if (state == S_WRITE) begin
                addr_to_mem <= addr_to_mem + ADDR_W'(1);
                remaining   <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 20;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              soc_clk = 1'b0;
    logic              soc_rst;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] addr_to_mem;
    logic [15:0]       data_to_mem;
    logic              en_to_memB;
    logic              rw_to_mem;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t wr_q[$];

    typedef struct {
        logic [15:0]       len;
        int                gap_max;
        bit                exp_done;
        bit                exp_err;
        logic [ADDR_W-1:0] exp_addr;
        int                exp_writes;
    } vec_t;

    mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .soc_clk     (soc_clk),
        .soc_rst     (soc_rst),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .addr_to_mem (addr_to_mem),
        .data_to_mem (data_to_mem),
        .en_to_memB  (en_to_memB),
        .rw_to_mem   (rw_to_mem),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .err         (err)
    );

    always #5 soc_clk = ~soc_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory-side monitor: every cycle with the enable low is one write.
    always @(negedge soc_clk) begin
        if (soc_rst === 1'b0 && en_to_memB === 1'b0) begin
            wr_q.push_back('{addr: addr_to_mem, data: data_to_mem});
            check("wr_rw_low", {31'd0, rw_to_mem}, 32'd0);
            check("wr_rx_ready_low", {31'd0, rx_ready}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge soc_clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && waited < 50) begin
            @(negedge soc_clk);
            waited++;
        end
        if (waited >= 50) begin
            check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge soc_clk);
        @(negedge soc_clk);
    endtask

    task automatic pulse_start();
        @(negedge soc_clk);
        start = 1'b1;
        @(negedge soc_clk);
        start = 1'b0;
        check("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_err_clr", {31'd0, err}, 32'd0);
        check("start_addr_clr", 32'(addr_to_mem), 32'd0);
        check("start_rx_ready", {31'd0, rx_ready}, 32'd1);
    endtask

    function automatic int pick_gap(input int gap_max);
        return (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    endfunction

    task automatic wait_finish();
        int n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 20) begin
            @(negedge soc_clk);
            n++;
        end
        check("finish_seen", {31'd0, (done === 1'b1 || err === 1'b1)}, 32'd1);
    endtask

    // One complete frame. Written words are either the fixed sequence
    // 1234, 5678, ... or random; the reference for the write list is simply
    // "word i goes to address i, in order".
    task automatic run_frame(input logic [15:0] len, input int gap_max, input bit fixed,
                             input bit poke, input bit exp_done, input bit exp_err,
                             input logic [ADDR_W-1:0] exp_addr, input int exp_writes);
        logic [15:0] words[$];
        for (int i = 0; i < exp_writes; i++) begin
            words.push_back(fixed ? 16'h1234 + 16'(i) * 16'h4444 : 16'($urandom));
        end
        wr_q.delete();
        pulse_start();
        send_byte(len[7:0], pick_gap(gap_max));
        send_byte(len[15:8], pick_gap(gap_max));
        if (poke) begin
            // A start edge in the middle of a load must be ignored.
            rx_valid = 1'b0;
            start    = 1'b1;
            @(negedge soc_clk);
            start    = 1'b0;
            @(negedge soc_clk);
            check("poke_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        end
        for (int i = 0; i < exp_writes; i++) begin
            send_byte(words[i][7:0], pick_gap(gap_max));
            send_byte(words[i][15:8], pick_gap(gap_max));
            // Write strobe is visible in the cycle right after the high byte.
            check("wr_latency", {31'd0, en_to_memB}, 32'd0);
        end
        rx_valid = 1'b0;
        wait_finish();
        check("end_done", {31'd0, done}, {31'd0, exp_done});
        check("end_err", {31'd0, err}, {31'd0, exp_err});
        check("end_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("end_addr", 32'(addr_to_mem), 32'(exp_addr));
        check("end_en_high", {31'd0, en_to_memB}, 32'd1);
        check("wr_count", 32'(wr_q.size()), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < wr_q.size(); i++) begin
            check("wr_addr", 32'(wr_q[i].addr), 32'(i % DEPTH));
            check("wr_data", 32'(wr_q[i].data), 32'(words[i]));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_addr"}, 32'(addr_to_mem), 32'd0);
        check({tag, "_data"}, 32'(data_to_mem), 32'd0);
        check({tag, "_en"}, {31'd0, en_to_memB}, 32'd1);
        check({tag, "_rw"}, {31'd0, rw_to_mem}, 32'd1);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{len: 16'd0,      gap_max: 2, exp_done: 1'b1, exp_err: 1'b0, exp_addr: 9'd0, exp_writes: 0};
        vecs[1] = '{len: 16'd513,    gap_max: 2, exp_done: 1'b0, exp_err: 1'b1, exp_addr: 9'd0, exp_writes: 0};
        vecs[2] = '{len: 16'hFFFF,   gap_max: 1, exp_done: 1'b0, exp_err: 1'b1, exp_addr: 9'd0, exp_writes: 0};
        vecs[3] = '{len: 16'd1,      gap_max: 3, exp_done: 1'b1, exp_err: 1'b0, exp_addr: 9'd1, exp_writes: 1};
        vecs[4] = '{len: 16'd5,      gap_max: 2, exp_done: 1'b1, exp_err: 1'b0, exp_addr: 9'd5, exp_writes: 5};
        vecs[5] = '{len: 16'd4,      gap_max: 0, exp_done: 1'b1, exp_err: 1'b0, exp_addr: 9'd4, exp_writes: 4};
        vecs[6] = '{len: 16'd512,    gap_max: 0, exp_done: 1'b1, exp_err: 1'b0, exp_addr: 9'd0, exp_writes: 512};

        soc_rst  = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge soc_clk);
        check_reset_values("reset");
        soc_rst = 1'b0;
        @(negedge soc_clk);

        // Bytes 02 00 34 12 78 56 -> 0x1234 @ 0, 0x5678 @ 1.
        run_frame(16'd2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd2, 2);

        // Table of lengths: empty, oversize, single, gapped, held valid, full bank.
        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].len, vecs[v].gap_max, 1'b0, 1'b0, vecs[v].exp_done,
                      vecs[v].exp_err, vecs[v].exp_addr, vecs[v].exp_writes);
        end

        // Stall of exactly TIMEOUT cycles after a low data byte aborts.
        wr_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        rx_valid = 1'b0;
        repeat (TIMEOUT - 1) @(negedge soc_clk);
        check("stall_pre_err", {31'd0, err}, 32'd0);
        check("stall_pre_hold", {31'd0, cpu_hold}, 32'd1);
        @(negedge soc_clk);
        check("stall_err", {31'd0, err}, 32'd1);
        check("stall_done", {31'd0, done}, 32'd0);
        check("stall_hold", {31'd0, cpu_hold}, 32'd0);
        check("stall_no_wr", 32'(wr_q.size()), 32'd0);

        // Stall of TIMEOUT-1 cycles is tolerated.
        wr_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, TIMEOUT - 1);
        check("edge_wr_latency", {31'd0, en_to_memB}, 32'd0);
        rx_valid = 1'b0;
        wait_finish();
        check("edge_done", {31'd0, done}, 32'd1);
        check("edge_err", {31'd0, err}, 32'd0);
        check("edge_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check("edge_wr_data", 32'(wr_q[0].data), 32'h3322);

        // Reset while waiting for a high data byte.
        wr_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAB, 0);
        rx_valid = 1'b0;
        soc_rst  = 1'b1;
        @(negedge soc_clk);
        check_reset_values("midrst");
        soc_rst = 1'b0;
        @(negedge soc_clk);
        check("midrst_no_wr", 32'(wr_q.size()), 32'd0);
        run_frame(16'd3, 2, 1'b0, 1'b0, 1'b1, 1'b0, 9'd3, 3);

        // Randomised frames, some with a start edge injected mid-load.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 6));
            run_frame(16'(n), 3, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                      ADDR_W'(n % DEPTH), n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
